instr_encoder: RTL and testbench

Packs structured instruction requests (group, operator, register and immediate fields) into 16-bit instruction words using the CPU's instruction format, checks each request for field/tag collisions, and emits legal words with a sequential program address into a small output FIFO. It is the write-side counterpart of the CPU decoder and sits in the program-load path between the host/loader interface and program memory. Illegal requests are consumed and dropped, and an error is reported.

---
 rtl/instr_encoder.sv | 192 +++++++++++++++++++
 tb/tb_instr_encoder.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// ---------------------------------------------------------------------------
// instr_encoder
//
// Packs structured instruction requests into 16-bit CPU instruction words.
// Each request is checked for collisions with the decoder's group tags:
//   - legal words are stamped with the program address counter (pc) and
//     queued in a small in-order output FIFO;
//   - illegal requests are consumed, dropped and reported on err/err_count.
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready   request handshake
//   in_group, in_op       instruction group code and operator (word[15:12])
//   in_rgv/rg1/rg2        register fields
//   in_val, in_rel        immediate (CRVMATH) and relative jump (RJMP) fields
//   load_addr, base_addr  load pc from base_addr
//   out_valid/out_ready   FIFO head handshake
//   out_word, out_addr    encoded word at the head and its program address
//   err                   one-cycle pulse after an illegal request was dropped
//   err_count             saturating count of dropped requests
// ---------------------------------------------------------------------------
module instr_encoder #(
    parameter int ADDR_WIDTH = 16,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            in_group,
    input  logic [3:0]            in_op,
    input  logic [2:0]            in_rgv,
    input  logic [2:0]            in_rg1,
    input  logic [2:0]            in_rg2,
    input  logic [7:0]            in_val,
    input  logic [7:0]            in_rel,
    input  logic                  load_addr,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [15:0]           out_word,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic                  err,
    output logic [7:0]            err_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    // Group codes shared with the CPU decoder (cpu_data.v GROUP_*).
    localparam logic [3:0] GROUP_CRVMATH       = 4'd0;
    localparam logic [3:0] GROUP_RJMP          = 4'd1;
    localparam logic [3:0] GROUP_CRRMATH       = 4'd2;
    localparam logic [3:0] GROUP_WRRMATH       = 4'd3;
    localparam logic [3:0] GROUP_WRRMATH_MEM   = 4'd4;
    localparam logic [3:0] GROUP_CRSMATH       = 4'd5;
    localparam logic [3:0] GROUP_WRSMATH       = 4'd6;
    localparam logic [3:0] GROUP_WRSMATH_STACK = 4'd7;
    localparam logic [3:0] GROUP_SFLAG         = 4'd8;
    localparam logic [3:0] GROUP_UFLAG         = 4'd9;
    localparam logic [3:0] GROUP_SPECIAL       = 4'd10;

    // Returns {legal, word}. A request is illegal whenever the decoder would
    // read the produced word back as a different group.
    function automatic logic [16:0] encode(
        input logic [3:0] group,
        input logic [3:0] op,
        input logic [2:0] rgv,
        input logic [2:0] rg1,
        input logic [2:0] rg2,
        input logic [7:0] val,
        input logic [7:0] rel
    );
        logic [15:0] w;
        logic        ok;
        logic        mem_op;
        w       = '0;
        ok      = 1'b1;
        w[15:12] = op;
        mem_op  = op[3] && (op != 4'b1011) && (op != 4'b1111);
        case (group)
            GROUP_CRVMATH: begin
                w[11:4] = val;
                w[3:1]  = rgv;
                ok      = ~val[0];      // val[0] lands on the tag bit 4
            end
            GROUP_RJMP: begin
                w[7:0] = rel;
                ok     = (rel[4:3] == 2'b10);
            end
            GROUP_CRRMATH: begin
                w[10:8] = rg2;
                w[7:5]  = rg1;
                w[4:0]  = 5'b11100;
            end
            GROUP_WRRMATH, GROUP_WRRMATH_MEM: begin
                w[10:8] = rg2;
                w[7:5]  = rg1;
                w[4:0]  = 5'b11101;
                ok      = (group == GROUP_WRRMATH_MEM) ? mem_op : ~mem_op;
            end
            GROUP_CRSMATH: begin
                w[7:5] = rg1;
                w[4:0] = 5'b11110;
            end
            GROUP_WRSMATH, GROUP_WRSMATH_STACK: begin
                w[7:5] = rg1;
                w[4:0] = 5'b11111;
                ok     = (group == GROUP_WRSMATH_STACK) ? (op[2:0] == 3'b111)
                                                        : (op[2:0] != 3'b111);
            end
            GROUP_SFLAG: begin
                w[7:5] = rg1;
                w[4:0] = 5'b11000;
            end
            GROUP_UFLAG: begin
                w[7:5] = rg1;
                w[4:0] = 5'b11001;
            end
            GROUP_SPECIAL: begin
                w[7:5] = rg1;
                w[4:0] = 5'b11011;
            end
            default: ok = 1'b0;
        endcase
        return {ok, w};
    endfunction

    logic                  active;
    logic [CNT_W-1:0]      count;
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr;
    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] stamp;
    logic [15:0]           word_mem [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] addr_mem [FIFO_DEPTH];
    logic [16:0]           enc;
    logic                  accept;
    logic                  legal;
    logic                  push;
    logic                  pop;

    assign enc    = encode(in_group, in_op, in_rgv, in_rg1, in_rg2, in_val, in_rel);
    assign legal  = enc[16];

    // 'active' holds in_ready low during reset and until the first edge after it.
    assign in_ready  = active && (count < CNT_W'(FIFO_DEPTH));
    assign accept    = in_valid && in_ready;
    assign push      = accept && legal;
    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready;

    // A coincident load stamps the accepted word with base_addr itself.
    assign stamp = load_addr ? base_addr : pc;

    assign out_word = out_valid ? word_mem[rd_ptr] : '0;
    assign out_addr = out_valid ? addr_mem[rd_ptr] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active    <= 1'b0;
            count     <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            pc        <= '0;
            err       <= 1'b0;
            err_count <= '0;
        end else begin
            active <= 1'b1;
            pc     <= push ? stamp + 1'b1 : stamp;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            err <= accept && !legal;
            if (accept && !legal && (err_count != 8'hFF))
                err_count <= err_count + 8'd1;
        end
    end

    // Storage is not reset; entries are only visible while counted valid.
    always_ff @(posedge clk) begin
        if (push) begin
            word_mem[wr_ptr] <= enc[15:0];
            addr_mem[wr_ptr] <= stamp;
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;

    localparam int AW    = 16;
    localparam int DEPTH = 2;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    in_group;
    logic [3:0]    in_op;
    logic [2:0]    in_rgv;
    logic [2:0]    in_rg1;
    logic [2:0]    in_rg2;
    logic [7:0]    in_val;
    logic [7:0]    in_rel;
    logic          load_addr;
    logic [AW-1:0] base_addr;
    logic          out_valid;
    logic          out_ready;
    logic [15:0]   out_word;
    logic [AW-1:0] out_addr;
    logic          err;
    logic [7:0]    err_count;

    instr_encoder #(.ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_group(in_group), .in_op(in_op),
        .in_rgv(in_rgv), .in_rg1(in_rg1), .in_rg2(in_rg2),
        .in_val(in_val), .in_rel(in_rel),
        .load_addr(load_addr), .base_addr(base_addr),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_word(out_word), .out_addr(out_addr),
        .err(err), .err_count(err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference model: queue of (word, address), program counter, error count.
    typedef struct { int w; int a; } ent_t;
    ent_t q[$];
    int   pc_m;
    int   errc_m;
    bit   last_acc;
    int   obs_addr[$];

    // Encoding from the format rules, written as plain arithmetic.
    function automatic void ref_enc(input int g, input int op, input int rgv, input int rg1,
                                    input int rg2, input int val, input int rel,
                                    output bit ok, output int w);
        bit mem_op;
        ok     = 1;
        w      = op * 4096;
        mem_op = (op >= 8) && (op != 11) && (op != 15);
        case (g)
            0:  begin w += val * 16 + rgv * 2; ok = (val % 2 == 0); end
            1:  begin w += rel; ok = ((rel / 8) % 4 == 2); end
            2:  w += rg2 * 256 + rg1 * 32 + 28;
            3:  begin w += rg2 * 256 + rg1 * 32 + 29; ok = !mem_op; end
            4:  begin w += rg2 * 256 + rg1 * 32 + 29; ok = mem_op; end
            5:  w += rg1 * 32 + 30;
            6:  begin w += rg1 * 32 + 31; ok = (op % 8 != 7); end
            7:  begin w += rg1 * 32 + 31; ok = (op % 8 == 7); end
            8:  w += rg1 * 32 + 24;
            9:  w += rg1 * 32 + 25;
            10: w += rg1 * 32 + 27;
            default: ok = 0;
        endcase
    endfunction

    // One clock: check pre-edge readiness, step the model, check post-edge outputs.
    task automatic cycle();
        bit ok;
        int w;
        bit exp_rdy;
        bit acc;
        bit pop;
        int base;
        exp_rdy = (q.size() < DEPTH);
        check("in_ready", in_ready, exp_rdy);
        acc = in_valid && exp_rdy;
        ref_enc(in_group, in_op, in_rgv, in_rg1, in_rg2, in_val, in_rel, ok, w);
        pop = (q.size() > 0) && out_ready;
        if (out_valid && out_ready) obs_addr.push_back(int'(out_addr));
        @(posedge clk);
        #1;
        if (pop) q.delete(0);
        base = load_addr ? int'(base_addr) : pc_m;
        if (acc && ok) begin
            q.push_back('{w, base});
            pc_m = (base + 1) % 65536;
        end else begin
            pc_m = base;
        end
        if (acc && !ok && errc_m < 255) errc_m++;
        last_acc = acc;
        check("out_valid", out_valid, q.size() != 0);
        if (q.size() != 0) begin
            check("out_word", out_word, q[0].w);
            check("out_addr", out_addr, q[0].a);
        end else begin
            check("out_word_idle", out_word, 0);
        end
        check("err", err, acc && !ok);
        check("err_count", err_count, errc_m);
    endtask

    task automatic set_req(input int g, input int op, input int rgv, input int rg1,
                           input int rg2, input int val, input int rel);
        in_valid = 1'b1;
        in_group = 4'(g);
        in_op    = 4'(op);
        in_rgv   = 3'(rgv);
        in_rg1   = 3'(rg1);
        in_rg2   = 3'(rg2);
        in_val   = 8'(val);
        in_rel   = 8'(rel);
    endtask

    task automatic idle_inputs();
        in_valid  = 1'b0;
        load_addr = 1'b0;
    endtask

    // Assert reset (asynchronously), check reset state, release and settle.
    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_word", out_word, 0);
        check("rst_out_addr", out_addr, 0);
        check("rst_err", err, 0);
        check("rst_err_count", err_count, 0);
        q.delete();
        pc_m   = 0;
        errc_m = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rel_in_ready", in_ready, 1);
    endtask

    // Directed single request followed by one idle cycle to drain.
    task automatic one(input string tag, input int g, input int op, input int rgv,
                       input int rg1, input int rg2, input int val, input int rel,
                       input bit exp_err, input int exp_word);
        set_req(g, op, rgv, rg1, rg2, val, rel);
        cycle();
        if (exp_err) check({tag, "_err"}, err, 1);
        else         check({tag, "_word"}, out_word, exp_word);
        idle_inputs();
        cycle();
    endtask

    logic [15:0] held_word;
    int          g;

    initial begin
        rst_n     = 1'b0;
        out_ready = 1'b1;
        base_addr = '0;
        set_req(0, 0, 0, 0, 0, 0, 0);
        idle_inputs();
        #3;
        do_reset();

        // Encoding of each format.
        set_req(2, 3, 0, 2, 5, 0, 0);
        cycle();
        check("crr_word", out_word, 16'h355C);
        check("crr_addr", out_addr, 0);
        idle_inputs();
        cycle();
        one("crv",       0, 1, 3, 0, 0, 8'h42, 0, 0, 16'h1426);
        one("crv_bad",   0, 1, 3, 0, 0, 8'h43, 0, 1, 0);
        check("crv_bad_cnt", err_count, 1);
        one("wrr",       3, 4'b1011, 0, 1, 0, 0, 0, 0, 16'hB03D);
        one("wrrmem_bad",4, 4'b1011, 0, 1, 0, 0, 0, 1, 0);
        one("rjmp",      1, 2, 0, 0, 0, 0, 8'h95, 0, 16'h2095);
        one("rjmp_bad",  1, 2, 0, 0, 0, 0, 8'h8D, 1, 0);
        one("stack",     7, 4'b0111, 0, 4, 0, 0, 0, 0, 16'h709F);
        one("wrs_bad",   6, 4'b0111, 0, 4, 0, 0, 0, 1, 0);

        // Backpressure: three legal words, FIFO of two.
        out_ready = 1'b0;
        obs_addr.delete();
        load_addr = 1'b1;
        base_addr = 16'h0000;
        set_req(2, 1, 0, 1, 1, 0, 0);
        cycle();
        load_addr = 1'b0;
        set_req(5, 2, 0, 3, 0, 0, 0);
        cycle();
        check("bp_full_ready", in_ready, 0);
        held_word = out_word;
        set_req(8, 3, 0, 6, 0, 0, 0);
        repeat (2) begin
            cycle();
            check("bp_hold_word", out_word, held_word);
            check("bp_hold_addr", out_addr, 0);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cycle();
            if (last_acc) in_valid = 1'b0;
        end
        check("bp_pops", obs_addr.size(), 3);
        if (obs_addr.size() >= 3) begin
            check("bp_addr0", obs_addr[0], 0);
            check("bp_addr1", obs_addr[1], 1);
            check("bp_addr2", obs_addr[2], 2);
        end

        // Address load coincident with an accept, then wrap.
        load_addr = 1'b1;
        base_addr = 16'hFFFF;
        set_req(9, 4, 0, 2, 0, 0, 0);
        cycle();
        check("load_addr", out_addr, 16'hFFFF);
        load_addr = 1'b0;
        set_req(10, 5, 0, 1, 0, 0, 0);
        cycle();
        check("wrap_addr", out_addr, 16'h0000);
        idle_inputs();
        cycle();

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            g = ($urandom_range(0, 3) != 0) ? $urandom_range(0, 10) : $urandom_range(11, 15);
            set_req(g, $urandom_range(0, 15), $urandom_range(0, 7), $urandom_range(0, 7),
                    $urandom_range(0, 7), $urandom_range(0, 255), $urandom_range(0, 255));
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            load_addr = ($urandom_range(0, 15) == 0);
            base_addr = 16'($urandom());
            cycle();
        end
        idle_inputs();
        out_ready = 1'b1;
        repeat (3) cycle();

        // Error counter saturation.
        set_req(15, 0, 0, 0, 0, 0, 0);
        repeat (260) cycle();
        check("sat_count", err_count, 255);
        idle_inputs();
        cycle();

        // Reset with words queued.
        out_ready = 1'b0;
        set_req(2, 6, 0, 1, 2, 0, 0);
        cycle();
        set_req(2, 7, 0, 3, 4, 0, 0);
        cycle();
        check("pre_rst_valid", out_valid, 1);
        do_reset();
        out_ready = 1'b1;
        set_req(5, 1, 0, 7, 0, 0, 0);
        cycle();
        check("post_rst_pc", out_addr, 0);
        idle_inputs();
        cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
